wb_mem_arbiter: RTL and testbench

//  Shares the single Wishbone memory port between instruction fetch (M0,
//  the icache line refill) and data access (M1, load/store unit).
//  A master owns the slave port from grant until it drops cyc, so cache-line

---
 rtl/wb_mem_arbiter_if.sv | 28 ++
 rtl/wb_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_mem_arbiter_if.sv
// Wishbone classic bus bundle between one master and one slave.
// The master modport drives the request side; the slave modport answers it.
interface wb_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              cyc;
  logic              stb;
  logic              we;
  logic [SEL_W-1:0]  sel;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_w;  // master -> slave write data
  logic [DATA_W-1:0] dat_r;  // slave -> master read data
  logic              ack;
  logic              err;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter for the shared memory port.
// M0 = instruction fetch, M1 = data access. The owner keeps the port until it
// drops cyc, so bursts are never split. A watchdog aborts stalled strobes.
module wb_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int FAIR    = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_i,
  wb_mem_arbiter_if.slave     m0_if,
  wb_mem_arbiter_if.slave     m1_if,
  wb_mem_arbiter_if.master    s_if,
  output logic [1:0]          grant_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    ABORT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic              owner;     // 0: M0, 1: M1 (valid in OWNx / ABORT)
  logic              own_cyc;
  logic              oth_cyc;
  logic              wd_fire;

  logic              s_cyc, s_stb, s_we;
  logic [SEL_W-1:0]  s_sel;
  logic [ADDR_W-1:0] s_adr;
  logic [DATA_W-1:0] s_dat;
  logic              m0_ack, m1_ack, m0_err, m1_err;

  // In ABORT the owner is remembered by last_owner, which was set on entry.
  assign owner   = (state_q == OWN1) || ((state_q == ABORT) && last_owner_q);
  assign own_cyc = owner ? m1_if.cyc : m0_if.cyc;
  assign oth_cyc = owner ? m0_if.cyc : m1_if.cyc;

  // State, last owner and watchdog registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so update order inside the block does not matter.
    if (rst_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      wd_q         <= wd_d;
    end
  end

  // Next-state, bus mux and watchdog decision.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statement can leave a value held (no latches).
    state_d      = state_q;
    last_owner_d = last_owner_q;
    wd_d         = '0;
    wd_fire      = 1'b0;
    s_cyc        = 1'b0;
    s_stb        = 1'b0;
    s_we         = 1'b0;
    s_sel        = '0;
    s_adr        = '0;
    s_dat        = '0;
    m0_ack       = 1'b0;
    m1_ack       = 1'b0;
    m0_err       = 1'b0;
    m1_err       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (m0_if.cyc && m1_if.cyc) begin
          // Round-robin flips away from the last owner; fixed priority picks M1.
          state_d = (FAIR != 0 && last_owner_q) ? OWN0 : OWN1;
        end else if (m0_if.cyc) begin
          state_d = OWN0;
        end else if (m1_if.cyc) begin
          state_d = OWN1;
        end
      end

      OWN0, OWN1: begin
        s_cyc = own_cyc;
        s_stb = owner ? m1_if.stb   : m0_if.stb;
        s_we  = owner ? m1_if.we    : m0_if.we;
        s_sel = owner ? m1_if.sel   : m0_if.sel;
        s_adr = owner ? m1_if.adr   : m0_if.adr;
        s_dat = owner ? m1_if.dat_w : m0_if.dat_w;
        // A real ack or err in the expiry cycle takes precedence.
        wd_fire = WD_EN && (wd_q == WD_LAST) && own_cyc && s_stb &&
                  !s_if.ack && !s_if.err;
        if (owner) begin
          m1_ack = s_if.ack;
          m1_err = s_if.err | wd_fire;
        end else begin
          m0_ack = s_if.ack;
          m0_err = s_if.err | wd_fire;
        end
        if (!own_cyc) begin
          state_d = oth_cyc ? (owner ? OWN0 : OWN1) : IDLE;
        end else if (wd_fire) begin
          state_d = ABORT;
        end
      end

      ABORT: begin
        // Slave port stays quiet until the aborted master lets go.
        if (!own_cyc) begin
          state_d = oth_cyc ? (owner ? OWN0 : OWN1) : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_d == OWN0) begin
      last_owner_d = 1'b0;
    end else if (state_d == OWN1) begin
      last_owner_d = 1'b1;
    end

    // Count only uninterrupted waiting strobes within one ownership.
    if ((state_d == state_q) && s_stb && !s_if.ack && !s_if.err) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // One-hot grant view of the current owner.
  always_comb begin
    grant_o = 2'b00;
    unique case (state_q)
      OWN0:    grant_o = 2'b01;
      OWN1:    grant_o = 2'b10;
      ABORT:   grant_o = last_owner_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  assign s_if.cyc   = s_cyc;
  assign s_if.stb   = s_stb;
  assign s_if.we    = s_we;
  assign s_if.sel   = s_sel;
  assign s_if.adr   = s_adr;
  assign s_if.dat_w = s_dat;

  assign m0_if.dat_r = s_if.dat_r;
  assign m1_if.dat_r = s_if.dat_r;
  assign m0_if.ack   = m0_ack;
  assign m1_if.ack   = m1_ack;
  assign m0_if.err   = m0_err;
  assign m1_if.err   = m1_err;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: a round-robin instance (A) and a fixed-priority
// instance (B), both with a 4-cycle watchdog, share the same stimulus.
module tb_wb_mem_arbiter;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;

  logic clk = 1'b0;
  logic rst_i;

  always #5 clk = ~clk;

  wb_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  wb_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  wb_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();
  wb_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bm0_if ();
  wb_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bm1_if ();
  wb_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bs_if ();

  logic [1:0] grant_a, grant_b;

  wb_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(1), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst_i(rst_i), .m0_if(m0_if), .m1_if(m1_if), .s_if(s_if),
    .grant_o(grant_a)
  );

  wb_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(0), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst_i(rst_i), .m0_if(bm0_if), .m1_if(bm1_if), .s_if(bs_if),
    .grant_o(grant_b)
  );

  // Fixed master request attributes; strobe follows cyc.
  assign m0_if.stb   = m0_if.cyc;
  assign m0_if.we    = 1'b0;
  assign m0_if.sel   = 4'hF;
  assign m0_if.adr   = A0;
  assign m0_if.dat_w = 32'hAAAA_0000;
  assign m1_if.stb   = m1_if.cyc;
  assign m1_if.we    = 1'b1;
  assign m1_if.sel   = 4'h3;
  assign m1_if.adr   = A1;
  assign m1_if.dat_w = 32'hBBBB_0000;

  // Instance B mirrors the same stimulus.
  assign bm0_if.cyc   = m0_if.cyc;
  assign bm0_if.stb   = m0_if.stb;
  assign bm0_if.we    = m0_if.we;
  assign bm0_if.sel   = m0_if.sel;
  assign bm0_if.adr   = m0_if.adr;
  assign bm0_if.dat_w = m0_if.dat_w;
  assign bm1_if.cyc   = m1_if.cyc;
  assign bm1_if.stb   = m1_if.stb;
  assign bm1_if.we    = m1_if.we;
  assign bm1_if.sel   = m1_if.sel;
  assign bm1_if.adr   = m1_if.adr;
  assign bm1_if.dat_w = m1_if.dat_w;
  assign bs_if.ack    = s_if.ack;
  assign bs_if.err    = s_if.err;
  assign bs_if.dat_r  = s_if.dat_r;

  typedef struct {
    logic        rst, c0, c1, ack, err;
    logic [1:0]  g;
    logic        scyc, a0, a1, e0, e1;
    logic [31:0] adr;
  } vec_t;

  vec_t        tbl_a[$];
  vec_t        tbl_b[$];
  vec_t        exp_q[$];
  logic [31:0] dat_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, c0, c1, ack, err,
                              input logic [1:0] g, input logic scyc, a0, a1,
                              e0, e1, input logic [31:0] adr);
    vec_t v;
    v.rst = rst; v.c0 = c0; v.c1 = c1; v.ack = ack; v.err = err;
    v.g = g; v.scyc = scyc; v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1;
    v.adr = adr;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, sample away from the edge.
  task automatic step(input vec_t t, input bit use_b, input string name);
    vec_t        e;
    logic [63:0] act;
    @(negedge clk);
    rst_i     = t.rst;
    m0_if.cyc = t.c0;
    m1_if.cyc = t.c1;
    s_if.ack  = t.ack;
    s_if.err  = t.err;
    s_if.dat_r = 32'h5A5A_0000;
    exp_q.push_back(t);
    #1;
    e = exp_q.pop_front();
    if (use_b)
      act = {25'd0, grant_b, bs_if.cyc, bm0_if.ack, bm1_if.ack, bm0_if.err,
             bm1_if.err, bs_if.adr};
    else
      act = {25'd0, grant_a, s_if.cyc, m0_if.ack, m1_if.ack, m0_if.err,
             m1_if.err, s_if.adr};
    check(name, act, {25'd0, e.g, e.scyc, e.a0, e.a1, e.e0, e.e1, e.adr});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; m0_if.cyc = 1'b0; m1_if.cyc = 1'b0;
    s_if.ack = 1'b0; s_if.err = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    int beats;
    int pops;
    logic [31:0] d;

    rst_i = 1'b1; m0_if.cyc = 1'b0; m1_if.cyc = 1'b0;
    s_if.ack = 1'b0; s_if.err = 1'b0; s_if.dat_r = '0;

    //              rst c0 c1 ak er  g    sc a0 a1 e0 e1 adr
    // Round-robin handover (A, last_owner=1 after reset)
    tbl_a.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 1, 1, 0, 2'b01, 1, 1, 0, 0, 0, A0));
    tbl_a.push_back(mk(0, 0, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, A0));
    tbl_a.push_back(mk(0, 0, 1, 1, 0, 2'b10, 1, 0, 1, 0, 0, A1));
    tbl_a.push_back(mk(0, 1, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0, A1));
    tbl_a.push_back(mk(0, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, A1));
    tbl_a.push_back(mk(0, 1, 0, 1, 0, 2'b01, 1, 1, 0, 0, 0, A0));
    tbl_a.push_back(mk(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, A0));
    tbl_a.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    // Watchdog expiry on an unanswered M1 strobe
    tbl_a.push_back(mk(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl_a.push_back(mk(0, 0, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0, A1));
    tbl_a.push_back(mk(0, 0, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0, A1));
    tbl_a.push_back(mk(0, 0, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0, A1));
    tbl_a.push_back(mk(0, 0, 1, 0, 0, 2'b10, 1, 0, 0, 0, 1, A1));
    tbl_a.push_back(mk(0, 0, 1, 1, 0, 2'b10, 0, 0, 0, 0, 0, 0));
    tbl_a.push_back(mk(0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0));
    tbl_a.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    // Ack coinciding with expiry: ack wins, ownership kept
    tbl_a.push_back(mk(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl_a.push_back(mk(0, 0, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0, A1));
    tbl_a.push_back(mk(0, 0, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0, A1));
    tbl_a.push_back(mk(0, 0, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0, A1));
    tbl_a.push_back(mk(0, 0, 1, 1, 0, 2'b10, 1, 0, 1, 0, 0, A1));
    tbl_a.push_back(mk(0, 0, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0, A1));
    // Reset mid-beat in OWN1, then M0 wins the tie
    tbl_a.push_back(mk(1, 0, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0, A1));
    tbl_a.push_back(mk(0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0, A0));
    tbl_a.push_back(mk(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, A0));
    tbl_a.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));

    // Fixed priority (B): M1 wins every tie
    tbl_b.push_back(mk(0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl_b.push_back(mk(0, 1, 1, 1, 0, 2'b10, 1, 0, 1, 0, 0, A1));
    tbl_b.push_back(mk(0, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, A1));
    tbl_b.push_back(mk(0, 1, 1, 0, 1, 2'b01, 1, 0, 0, 1, 0, A0));
    tbl_b.push_back(mk(0, 0, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, A0));
    tbl_b.push_back(mk(0, 1, 1, 1, 0, 2'b10, 1, 0, 1, 0, 0, A1));
    tbl_b.push_back(mk(0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, A1));
    tbl_b.push_back(mk(0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl_b.push_back(mk(0, 1, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0, A1));
    tbl_b.push_back(mk(0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, A1));
    tbl_b.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));

    do_reset();
    for (int i = 0; i < tbl_a.size(); i++)
      step(tbl_a[i], 1'b0, $sformatf("fair_row%0d", i));

    // M0 8-beat burst with ack every second cycle; M1 asks from beat 2.
    do_reset();
    @(negedge clk);
    rst_i = 1'b0; m0_if.cyc = 1'b1; m1_if.cyc = 1'b0; s_if.ack = 1'b0;
    beats = 0;
    pops  = 0;
    for (int k = 0; k < 40 && beats < 8; k++) begin
      @(negedge clk);
      m1_if.cyc  = (beats >= 2);
      s_if.ack   = (k % 2 == 1);
      s_if.dat_r = 32'hD000_0000 + 32'(beats);
      if (s_if.ack) dat_q.push_back(32'hD000_0000 + 32'(beats));
      #1;
      check($sformatf("burst_hold%0d", k), {62'd0, grant_a, 1'b0} >> 1,
            {62'd0, 2'b01, 1'b0} >> 1);
      check($sformatf("burst_m1_ack%0d", k), {63'd0, m1_if.ack}, 64'd0);
      if (m0_if.ack) begin
        if (dat_q.size() == 0) begin
          check("burst_unexpected_ack", 64'd1, 64'd0);
        end else begin
          d = dat_q.pop_front();
          pops++;
          check($sformatf("burst_data%0d", pops), {32'd0, m0_if.dat_r},
                {32'd0, d});
        end
      end
      if (s_if.ack) beats++;
    end
    check("burst_beats_acked", 64'(pops), 64'd8);
    check("burst_queue_empty", 64'(dat_q.size()), 64'd0);
    @(negedge clk);
    m0_if.cyc = 1'b0; s_if.ack = 1'b0; m1_if.cyc = 1'b1;
    #1;
    check("burst_release", {61'd0, grant_a, s_if.cyc}, {61'd0, 2'b01, 1'b0});
    @(negedge clk);
    #1;
    check("burst_m1_takes", {29'd0, grant_a, s_if.cyc, s_if.adr},
          {29'd0, 2'b10, 1'b1, A1});
    @(negedge clk);
    m1_if.cyc = 1'b0;

    do_reset();
    for (int i = 0; i < tbl_b.size(); i++)
      step(tbl_b[i], 1'b1, $sformatf("prio_row%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
